// File: rtl/arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_rr
//  Description : Three-requester round-robin bus arbiter with registered
//                one-hot grants, request locking and an optional tenure
//                limit that revokes a grant while another requester waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr #(
    parameter int MAX_HOLD   = 0,
    parameter int RESET_LAST = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    output logic gnt0,
    output logic gnt1,
    output logic gnt2
);

    // Hold counter is only as wide as MAX_HOLD needs (at least one bit).
    localparam int             c_cnt_w      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_sat = (MAX_HOLD > 0) ? c_cnt_w'(MAX_HOLD) : '1;
    localparam logic [1:0]     c_reset_last = 2'(RESET_LAST);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_g0   = 2'd1;
    localparam logic [1:0] c_st_g1   = 2'd2;
    localparam logic [1:0] c_st_g2   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [1:0]         last_q,  last_d;
    logic [c_cnt_w-1:0] cnt_q,   cnt_d;
    logic [2:0]         gnt_q,   gnt_d;

    logic [2:0] w_req;
    logic [2:0] w_own_mask;
    logic [2:0] w_others;
    logic       w_own_req;
    logic [1:0] w_own_idx;

    assign w_req = {req2, req1, req0};

    // First requester in r, scanning from+1, from+2, from+3 (mod 3).
    // Caller guarantees r is non-zero.
    function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [2:0] r);
        logic [1:0] win;
        case (from)
            2'd0:    win = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd1:    win = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: win = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
        return win;
    endfunction

    // Grant states are encoded as owner index + 1, IDLE as zero.
    function automatic logic [1:0] idx_to_state(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

    // Decode the current owner's request and the competing requests.
    always_comb begin
        w_own_mask = 3'b000;
        case (state_q)
            c_st_g0: w_own_mask = 3'b001;
            c_st_g1: w_own_mask = 3'b010;
            c_st_g2: w_own_mask = 3'b100;
            default: w_own_mask = 3'b000;
        endcase
        w_own_idx = state_q - 2'd1;
        w_own_req = |(w_req & w_own_mask);
        w_others  = w_req & ~w_own_mask;
    end

    // State register plus registered grant outputs; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_st_idle;
            last_q  <= c_reset_last;
            cnt_q   <= '0;
            gnt_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state: idle arbitration, release hand-off, and tenure revocation.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == c_st_idle) begin
            if (|w_req) begin
                state_d = idx_to_state(rr_pick(last_q, w_req));
            end
        end else if (!w_own_req) begin
            // Owner released: hand straight to the next requester, no gap.
            last_d  = w_own_idx;
            state_d = (|w_req) ? idx_to_state(rr_pick(w_own_idx, w_req)) : c_st_idle;
        end else if ((MAX_HOLD > 0) && (cnt_q == c_cnt_sat) && (|w_others)) begin
            // Tenure expired with someone waiting: the owner is excluded
            // from the scan so it rejoins the rotation behind the others.
            last_d  = w_own_idx;
            state_d = idx_to_state(rr_pick(w_own_idx, w_others));
        end else if (cnt_q != c_cnt_sat) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Output decode from the next state so grants leave directly from flops.
    always_comb begin
        gnt_d = 3'b000;
        case (state_d)
            c_st_g0: gnt_d = 3'b001;
            c_st_g1: gnt_d = 3'b010;
            c_st_g2: gnt_d = 3'b100;
            default: gnt_d = 3'b000;
        endcase
    end

    assign gnt0 = gnt_q[0];
    assign gnt1 = gnt_q[1];
    assign gnt2 = gnt_q[2];

endmodule
`default_nettype wire

// File: tb/tb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbiter_rr
//  Description : Self-checking bench for arbiter_rr. Two instances share the
//                same requests: one with unlimited tenure, one with a tenure
//                limit of 4. Each is compared against an owner/last/tenure
//                reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] rq  = 3'b000;
    logic       g0a, g1a, g2a, g0b, g1b, g2b;
    logic [2:0] ga, gb;

    int tests = 0;
    int fails = 0;

    // Reference model state per instance: owner (-1 = none), last, tenure.
    int own [2];
    int lst [2];
    int ten [2];
    int mh  [2] = '{0, 4};
    int use_cnt [3];

    always #5 clk = ~clk;

    assign ga = {g2a, g1a, g0a};
    assign gb = {g2b, g1b, g0b};

    arbiter_rr #(.MAX_HOLD(0), .RESET_LAST(2)) dut_a (
        .clk(clk), .rst(rst), .req0(rq[0]), .req1(rq[1]), .req2(rq[2]),
        .gnt0(g0a), .gnt1(g1a), .gnt2(g2a)
    );

    arbiter_rr #(.MAX_HOLD(4), .RESET_LAST(2)) dut_b (
        .clk(clk), .rst(rst), .req0(rq[0]), .req1(rq[1]), .req2(rq[2]),
        .gnt0(g0b), .gnt1(g1b), .gnt2(g2b)
    );

    function automatic int pick(input int from, input logic [2:0] r);
        for (int s = 1; s <= 3; s++) begin
            int c;
            c = (from + s) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [2:0] expv(input int k);
        logic [2:0] v;
        v = 3'b000;
        if (own[k] >= 0) v[own[k]] = 1'b1;
        return v;
    endfunction

    task automatic model_reset(input int k);
        own[k] = -1;
        lst[k] = 2;
        ten[k] = 0;
    endtask

    task automatic model_step(input int k, input logic [2:0] r);
        logic [2:0] oth;
        if (own[k] < 0) begin
            if (|r) begin
                own[k] = pick(lst[k], r);
                ten[k] = 0;
            end
        end else if (!r[own[k]]) begin
            lst[k] = own[k];
            own[k] = pick(own[k], r);
            ten[k] = 0;
        end else begin
            oth = r;
            oth[own[k]] = 1'b0;
            if (mh[k] > 0 && ten[k] >= mh[k] && |oth) begin
                lst[k] = own[k];
                own[k] = pick(own[k], oth);
                ten[k] = 0;
            end else begin
                ten[k] = ten[k] + 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) model_reset(k);
            else      model_step(k, rq);
        end
        #1;
        check({tag, "_a"}, ga, expv(0));
        check({tag, "_b"}, gb, expv(1));
        check({tag, "_onehot_a"}, {2'b00, $onehot0(ga)}, 3'b001);
        check({tag, "_onehot_b"}, {2'b00, $onehot0(gb)}, 3'b001);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);

        // Reset held with every request high.
        rst = 1'b0;
        rq  = 3'b111;
        for (int i = 0; i < 5; i++) cycle("reset");
        check("reset_zero", ga | gb, 3'b000);

        // Release away from the edge; requester 0 wins first.
        rst = 1'b1;
        cycle("release");
        check("release_gnt0", ga, 3'b001);

        // Single requester 1 for four cycles.
        rq = 3'b000;
        cycle("idle");
        cycle("idle");
        rq = 3'b010;
        for (int i = 0; i < 4; i++) begin
            cycle("single");
            check("single_gnt1", ga, 3'b010);
        end
        rq = 3'b000;
        cycle("single_end");
        check("single_drop", ga, 3'b000);

        // Fairness: each requester uses its grant two cycles, rests one.
        rq = 3'b111;
        for (int i = 0; i < 3; i++) use_cnt[i] = 0;
        cycle("fair");
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!rq[i]) begin
                    rq[i] = 1'b1;
                end else if (own[0] == i) begin
                    use_cnt[i]++;
                    if (use_cnt[i] == 2) begin
                        rq[i]      = 1'b0;
                        use_cnt[i] = 0;
                    end
                end
            end
            cycle("fair");
            check("fair_nogap", {2'b00, |ga}, 3'b001);
        end
        rq = 3'b000;
        cycle("drain");
        cycle("drain");

        // Lock: requester 0 holds ten cycles, requester 2 arrives at cycle 3.
        rq = 3'b001;
        cycle("lock_start");
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) rq[2] = 1'b1;
            cycle("lock");
            check("lock_gnt0", ga, 3'b001);
        end
        rq[0] = 1'b0;
        cycle("lock_handoff");
        check("lock_gnt2", ga, 3'b100);
        rq = 3'b000;
        cycle("drain");

        // Tenure limit: requester 0 holds forever, requester 1 contends.
        rq = 3'b001;
        cycle("tenure_start");
        rq = 3'b011;
        for (int c = 0; c < 12; c++) cycle("tenure");
        rq = 3'b001;
        for (int c = 0; c < 4; c++) cycle("tenure_return");
        rq = 3'b000;
        cycle("drain");

        // Asynchronous reset while requester 2 owns the bus.
        rq = 3'b100;
        cycle("async_pre");
        cycle("async_pre");
        check("async_gnt2", ga & gb, 3'b100);
        #2;
        rst = 1'b0;
        #1;
        check("async_drop_a", ga, 3'b000);
        check("async_drop_b", gb, 3'b000);
        model_reset(0);
        model_reset(1);
        cycle("async_hold");
        cycle("async_hold");
        rst = 1'b1;
        rq  = 3'b111;
        cycle("async_restart");
        check("async_restart_gnt0", ga, 3'b001);

        // Randomized requests: each line toggles with probability 1/4.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(3) == 0) rq[i] = ~rq[i];
            end
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- Three-requester, round-robin bus arbiter with registered one-hot grants.
- Each requester raises reqN and holds it for as long as it needs the shared resource. Its grant gntN stays asserted until the requester drops reqN, or until a tenure limit expires while another requester is waiting.
- The arbiter sits between three independent master agents and a single shared resource.

Parameters:
- MAX_HOLD, 0, maximum consecutive grant cycles for one requester while another is waiting. 0 = unlimited tenure.
- RESET_LAST, 2, index (0..2) treated as "last granted" after reset. The default makes requester 0 highest priority first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req0  input  1  request from requester 0; level, held until done
- req1  input  1  request from requester 1
- req2  input  1  request from requester 2
- gnt0  output  1  grant to requester 0, registered
- gnt1  output  1  grant to requester 1, registered
- gnt2  output  1  grant to requester 2, registered

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt0=gnt1=gnt2=0, state=IDLE, last=RESET_LAST, hold counter=0.
  - The block leaves reset on the first rising clk edge with rst=1.
  - Reset asserted mid-grant drops all grants immediately, without waiting for a clock edge.
- Grant vector:
  - At most one gnt is ever high (one-hot or zero).
  - All outputs come directly from flops; there is no combinational path from req to gnt.
- States: IDLE, G0, G1, G2. gntN=1 exactly in state GN.
- IDLE:
  - At each edge, if any req is high, move to GK, where K is the first requesting index scanning last+1, last+2, last+3 (mod 3).
  - Latency: req sampled high at edge t gives gnt high after edge t.
- GN, normal case:
  - While reqN=1 the grant is held (locked). Each held cycle increments the hold counter, saturating.
- GN with reqN=0 at an edge:
  - Set last=N.
  - If another req is high, go directly to the next winner by round-robin from N. There is no idle cycle between grants.
  - Otherwise go to IDLE.
- Tenure limit:
  - Applies when MAX_HOLD>0, the hold counter has reached MAX_HOLD, reqN is still 1, and another req is high.
  - Revoke: set last=N and move to the next waiting requester by round-robin.
  - The revoked requester keeps its req high and is re-granted later in its normal round-robin turn.
- The hold counter clears on every state change.
- Round-robin guarantee: with all three requesting continuously, grant order is 0,1,2,0,... from reset defaults.
- Simultaneous events:
  - A requester that drops req in the same cycle another raises req is handled by the normal GN→next rule.
  - A new request arriving during another's tenure never preempts it, except via MAX_HOLD.
- Requester-side rule:
  - Requesters assert req, hold it until gnt is seen, use the resource for 1..n cycles, then deassert.
  - req deasserted before grant is legal (withdrawn). A requester never granted is simply skipped.
- The internal hold counter width is sized to hold MAX_HOLD (minimum 1 bit).

Test Plan:
- Reset: hold rst=0 with all req=1 for 5 cycles → gnt0/1/2 all 0. Release rst → gnt0=1 one edge later.
- Single requester: req1=1 for 4 cycles then 0 → gnt1 high for 4 consecutive cycles starting 1 edge after req1 rises; gnt1=0 one edge after req1 falls; state returns to IDLE.
- Round-robin fairness: req0=req1=req2=1. Each requester drops req 2 cycles after its gnt and re-raises it 1 cycle later. Run 30 cycles → grant sequence is 0,1,2,0,1,2 with no gap cycles. Never more than one gnt high (assert every cycle).
- Hold/lock: gnt0 active with req0 held 10 cycles, req2 raised at cycle 3, MAX_HOLD=0 → gnt0 stays high all 10 cycles; gnt2 rises the edge after req0 drops.
- Tenure limit: MAX_HOLD=4, req0 held forever, req1 raised → gnt0 revoked after 4 held cycles, gnt1 granted next edge; gnt0 returns after req1 releases.
- Async reset mid-grant: assert rst=0 between clock edges while gnt2=1 → gnt2 falls immediately without a clock edge. After release, arbitration restarts from RESET_LAST.
